// File: rtl/weight_mem_pkg.sv
// Purpose : shared types and default sizes for the weight memory sequencer.
// Contents: sequencer state enum and default parameter values.
// Ports   : none (package).
package weight_mem_pkg;

   // Default sizes of the weight set handled by one sequencer.
   localparam int DEF_IN_WIDTH     = 121;
   localparam int DEF_WEIGHT_WIDTH = 16;
   localparam int DEF_MEMORY_DEPTH = 7;

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_FULL = 2'd1,
      ST_READ = 2'd2
   } state_t;

endpackage

// File: rtl/weight_mem_sequencer.sv
// Purpose : fills an external weight memory from a load stream, then replays the
//           stored set as a valid/ready stream on each start pulse.
// Ports   : clk/reset_n (sync, active-low); load_valid/load_data/load_ready in;
//           reload/start controls, busy/done status; out_valid/out_data/out_last/
//           out_ready stream; mem_address/mem_data_in/mem_write_enable/mem_data_out
//           to a memory with 1-cycle registered read data.
module weight_mem_sequencer
   import weight_mem_pkg::*;
#(
   parameter int inWidth     = DEF_IN_WIDTH,
   parameter int weightWidth = DEF_WEIGHT_WIDTH,
   parameter int memoryDepth = DEF_MEMORY_DEPTH
)(
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          load_valid,
   input  logic signed [weightWidth-1:0] load_data,
   output logic                          load_ready,
   input  logic                          reload,
   input  logic                          start,
   output logic                          busy,
   output logic                          done,
   output logic                          out_valid,
   output logic signed [weightWidth-1:0] out_data,
   output logic                          out_last,
   input  logic                          out_ready,
   output logic        [memoryDepth-1:0] mem_address,
   output logic signed [weightWidth-1:0] mem_data_in,
   output logic                          mem_write_enable,
   input  logic signed [weightWidth-1:0] mem_data_out
);

   localparam logic [memoryDepth-1:0] LAST_ADDR = memoryDepth'(inWidth - 1);

   state_t                 state_q, state_d;
   logic [memoryDepth-1:0] wr_ptr_q, wr_ptr_d;
   logic [memoryDepth-1:0] rd_ptr_q, rd_ptr_d;
   // Address whose data the memory is currently returning on mem_data_out.
   logic [memoryDepth-1:0] disp_addr_q, disp_addr_d;
   // Set once LAST_ADDR has been issued so no address beyond it is presented.
   logic                   issued_all_q, issued_all_d;
   logic                   out_valid_q, out_valid_d;
   logic                   done_q, done_d;
   logic                   stall;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= ST_LOAD;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         disp_addr_q  <= '0;
         issued_all_q <= 1'b0;
         out_valid_q  <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         disp_addr_q  <= disp_addr_d;
         issued_all_q <= issued_all_d;
         out_valid_q  <= out_valid_d;
         done_q       <= done_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      wr_ptr_d         = wr_ptr_q;
      rd_ptr_d         = rd_ptr_q;
      disp_addr_d      = disp_addr_q;
      issued_all_d     = issued_all_q;
      out_valid_d      = 1'b0;
      done_d           = 1'b0;
      load_ready       = 1'b0;
      mem_write_enable = 1'b0;
      mem_address      = '0;
      mem_data_in      = '0;
      stall            = out_valid_q & ~out_ready;

      case (state_q)
         ST_LOAD: begin
            // Qualified by reset_n so a beat offered during reset never writes.
            load_ready = reset_n;
            if (load_valid && reset_n) begin
               mem_write_enable = 1'b1;
               mem_address      = wr_ptr_q;
               mem_data_in      = load_data;
               if (wr_ptr_q == LAST_ADDR) begin
                  wr_ptr_d = '0;
                  state_d  = ST_FULL;
               end else begin
                  wr_ptr_d = wr_ptr_q + 1'b1;
               end
            end
         end

         ST_FULL: begin
            if (reload) begin
               state_d  = ST_LOAD;
               wr_ptr_d = '0;
            end else if (start) begin
               state_d      = ST_READ;
               rd_ptr_d     = '0;
               issued_all_d = 1'b0;
            end
         end

         ST_READ: begin
            if (stall) begin
               // Re-read the displayed word so the registered memory output holds.
               mem_address = disp_addr_q;
               out_valid_d = 1'b1;
            end else if (out_valid_q && (disp_addr_q == LAST_ADDR)) begin
               state_d = ST_FULL;
               done_d  = 1'b1;
            end else if (!issued_all_q) begin
               mem_address = rd_ptr_q;
               disp_addr_d = rd_ptr_q;
               out_valid_d = 1'b1;
               if (rd_ptr_q == LAST_ADDR) begin
                  issued_all_d = 1'b1;
               end else begin
                  rd_ptr_d = rd_ptr_q + 1'b1;
               end
            end
         end

         default: state_d = ST_LOAD;
      endcase
   end

   assign busy      = (state_q == ST_READ);
   assign done      = done_q;
   assign out_valid = out_valid_q;
   // Memory output is not reset by this block, so mask it while nothing is shown.
   assign out_data  = out_valid_q ? mem_data_out : '0;
   assign out_last  = out_valid_q && (disp_addr_q == LAST_ADDR);

endmodule

// File: doc/weight_mem_sequencer.md
WEIGHT_MEM_SEQUENCER -- requirements
Module: weight_mem_sequencer

Interface
REQ-001 SHALL have parameter inWidth, default 121, number of weight words per layer.
REQ-002 SHALL have parameter weightWidth, default 16, weight word width.
REQ-003 SHALL have parameter memoryDepth, default 7, address width; 2^memoryDepth >= inWidth.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port load_valid  input  1  load beat offered.
REQ-007 SHALL have port load_data  input  weightWidth (signed)  weight to store.
REQ-008 SHALL have port load_ready  output  1  load beat can be accepted.
REQ-009 SHALL have port reload  input  1  pulse; discard stored set, restart loading at address 0.
REQ-010 SHALL have port start  input  1  pulse; begin one sequential read pass.
REQ-011 SHALL have port busy  output  1  high while in READ.
REQ-012 SHALL have port done  output  1  one-cycle pulse after last word of a pass is accepted.
REQ-013 SHALL have port out_valid  output  1  out_data holds a valid weight.
REQ-014 SHALL have port out_data  output  weightWidth (signed)  weight read back.
REQ-015 SHALL have port out_last  output  1  qualifies word at address inWidth-1.
REQ-016 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-017 SHALL have port mem_address  output  memoryDepth  address to weight memory.
REQ-018 SHALL have port mem_data_in  output  weightWidth (signed)  write data to weight memory.
REQ-019 SHALL have port mem_write_enable  output  1  write strobe to weight memory.
REQ-020 SHALL have port mem_data_out  input  weightWidth (signed)  memory registered read data (1-cycle latency, updated only when mem_write_enable=0).

Function
REQ-021 SHALL implement states LOAD, FULL, READ; reset state LOAD.
REQ-022 LOAD: load_ready=1; beat accepted when load_valid&load_ready; on accept mem_write_enable=1, mem_address=wr_ptr, mem_data_in=load_data (combinational), wr_ptr increments.
REQ-023 LOAD: accept at wr_ptr=inWidth-1 SHALL move to FULL next cycle, wr_ptr cleared; start in LOAD ignored.
REQ-024 FULL: load_ready=0, mem_write_enable=0; start -> READ with rd_ptr=0; reload -> LOAD with wr_ptr=0; reload wins if both asserted.
REQ-025 READ: mem_write_enable=0 always; word at address A SHALL appear on out_data with out_valid=1 exactly one cycle after A is presented with no stall.
REQ-026 Stall (out_valid=1, out_ready=0): mem_address SHALL re-present the address of the currently displayed word and rd_ptr SHALL hold, so out_data is unchanged.
REQ-027 No stall: mem_address=rd_ptr, rd_ptr increments until inWidth-1 issued; no address >= inWidth SHALL be issued.
REQ-028 out_last=1 exactly when out_valid=1 and displayed word came from address inWidth-1.
REQ-029 Acceptance of the out_last word SHALL return to FULL next cycle, out_valid=0, done=1 for one cycle; stored weights remain for further passes.
REQ-030 start, reload, load_valid during READ SHALL be ignored; busy=1 for every READ cycle.
REQ-031 Outside READ, out_valid=0, out_last=0.

Reset
REQ-032 reset_n=0 at a clock edge SHALL force state LOAD, wr_ptr=0, rd_ptr=0, out_valid=0, out_data=0, out_last=0, done=0, busy=0, mem_write_enable=0, mem_address=0, mem_data_in=0, load_ready=1 after release.
REQ-033 Reset mid-LOAD or mid-READ SHALL abandon the operation with no further memory write; memory contents are not cleared by this block.

Structure
REQ-034 State enum and default parameter values SHALL live in shared package weight_mem_pkg.
REQ-035 No sub-module; the weight memory is instantiated by the parent beside this block, reset polarity adapted there.

Verification (inWidth=4)
REQ-036 Load 0x0011,0x0022,0x0033,0x0044 back-to-back -> writes to addresses 0..3 on 4 consecutive cycles, load_ready=0 from cycle 5.
REQ-037 start with out_ready=1 -> out_data 0x0011,0x0022,0x0033,0x0044 on consecutive cycles, out_last with 0x0044, done one cycle after.
REQ-038 out_ready=0 for 3 cycles while 0x0022 displayed -> 0x0022 held 3 cycles, mem_address=1 during stall, no word lost or duplicated.
REQ-039 reload and start same cycle in FULL -> LOAD, busy stays 0, next load writes address 0.
REQ-040 reset_n=0 mid-READ after 2 words -> all outputs 0 next cycle, state LOAD, load_ready=1 after release.
REQ-041 start asserted in LOAD with 2 words stored -> ignored, no read issued, loading continues at address 2.
